// File: rtl/jk_bank_driver.sv
`timescale 1ns/1ps
// jk_bank_driver
// Drives a bank of WIDTH JK flip-flops to a requested word. The J/K word comes
// from the JK excitation table applied to the bank's current Q and the target.
// CE is pulsed for one cycle, Q is read back one cycle later, and the drive is
// retried up to MAX_RETRY times before giving up.
//
// Build option:
//   JK_DRV_TOGGLE_EN  defined   -> changing bits are driven with J=K=1 (toggle)
//                     undefined -> changing bits use set (J1 K0) / reset (J0 K1)
//
// Ports:
//   CLK        clock, all state changes on the rising edge
//   R          synchronous active-high reset, priority over START
//   START      request, sampled only in IDLE
//   TARGET     requested Q word, latched when START is accepted
//   Q_FB       Q outputs of the driven bank
//   J, K       registered J/K inputs of the bank
//   CE         registered clock enable of the bank, one-cycle pulse per attempt
//   BUSY       high whenever the controller is not IDLE
//   DONE       one-cycle pulse: bank matched the target
//   ERR        one-cycle pulse: retries exhausted without a match
//   RETRY_CNT  retries used by the current/last operation
//
// state | meaning
// IDLE  | waiting for START; J, K, CE held low
// DRIVE | CE high for this cycle; bank samples J/K at the closing edge
// CHECK | compare Q_FB with latched target; finish, retry or error
module jk_bank_driver #(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             START,
    input  logic [WIDTH-1:0] TARGET,
    input  logic [WIDTH-1:0] Q_FB,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             CE,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [2:0]       RETRY_CNT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] tgt_nx;
    logic [WIDTH-1:0] exc_tgt;
    logic [WIDTH-1:0] exc_j;
    logic [WIDTH-1:0] exc_k;
    logic [WIDTH-1:0] j_nx;
    logic [WIDTH-1:0] k_nx;
    logic             ce_nx;
    logic             done_nx;
    logic             err_nx;
    logic [2:0]       retry_nx;
    logic             match;
    logic             can_retry;

    assign BUSY      = (state != IDLE);
    assign match     = (Q_FB == tgt);
    assign can_retry = (RETRY_CNT < RETRY_LIMIT);

    // On acceptance the target is not latched yet, so excite from the live input.
    assign exc_tgt = (state == IDLE) ? TARGET : tgt;

`ifdef JK_DRV_TOGGLE_EN
    assign exc_j = Q_FB ^ exc_tgt;
    assign exc_k = Q_FB ^ exc_tgt;
`else
    assign exc_j = ~Q_FB & exc_tgt;
    assign exc_k = Q_FB & ~exc_tgt;
`endif

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (R) begin
            state     <= IDLE;
            tgt       <= '0;
            J         <= '0;
            K         <= '0;
            CE        <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            RETRY_CNT <= 3'd0;
        end else begin
            state     <= state_nx;
            tgt       <= tgt_nx;
            J         <= j_nx;
            K         <= k_nx;
            CE        <= ce_nx;
            DONE      <= done_nx;
            ERR       <= err_nx;
            RETRY_CNT <= retry_nx;
        end
    end

    // Next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (START) state_nx = DRIVE;
            DRIVE:   state_nx = CHECK;
            CHECK: begin
                if (match)          state_nx = IDLE;
                else if (can_retry) state_nx = DRIVE;
                else                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs; J/K/CE/DONE/ERR default low so
    // every pulse lasts exactly one cycle.
    always_comb begin
        tgt_nx   = tgt;
        j_nx     = '0;
        k_nx     = '0;
        ce_nx    = 1'b0;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        retry_nx = RETRY_CNT;
        case (state)
            IDLE: begin
                if (START) begin
                    tgt_nx   = TARGET;
                    retry_nx = 3'd0;
                    j_nx     = exc_j;
                    k_nx     = exc_k;
                    ce_nx    = 1'b1;
                end
            end
            CHECK: begin
                if (match) begin
                    done_nx = 1'b1;
                end else if (can_retry) begin
                    retry_nx = RETRY_CNT + 3'd1;
                    j_nx     = exc_j;
                    k_nx     = exc_k;
                    ce_nx    = 1'b1;
                end else begin
                    err_nx = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
